count_ctrl: RTL and testbench

- Initiator for the up-counting sub-counter: accepts a target count over a valid/ready command channel and programs the counter's stopcount.
- Holds the counter in clear, then drives start and watches status.
- Returns a response: elapsed cycles, final count, completion code.
- Sits between a test/host sequencer and one counter instance; lets runs be issued back to back without a global reset.

---
 rtl/count_ctrl_pkg.sv | 19 +
 rtl/count_ctrl_rsp_reg.sv | 50 +++++
 rtl/count_ctrl.sv | 150 +++++++++++++++
 tb/tb_count_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl counter initiator.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_TIMEOUT  = 2'd1,
    RSP_ABORT    = 2'd2,
    RSP_MISMATCH = 2'd3
  } rsp_code_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd1024;

endpackage

// File: rtl/count_ctrl_rsp_reg.sv
// Response holding register: captures code/cycles/count on load and keeps
// them stable until the consumer accepts them.
module count_ctrl_rsp_reg
  import count_ctrl_pkg::*;
#(
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  rsp_code_e        load_code,
  input  logic [CYC_W-1:0] load_cycles,
  input  logic [31:0]      load_count,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output rsp_code_e        rsp_code,
  output logic [CYC_W-1:0] rsp_cycles,
  output logic [31:0]      rsp_count
);

  logic             valid_r;
  rsp_code_e        code_r;
  logic [CYC_W-1:0] cycles_r;
  logic [31:0]      count_r;

  // Capture on load, drop valid on handshake, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r  <= 1'b0;
      code_r   <= RSP_OK;
      cycles_r <= {CYC_W{1'b0}};
      count_r  <= 32'd0;
    end else if (load) begin
      valid_r  <= 1'b1;
      code_r   <= load_code;
      cycles_r <= load_cycles;
      count_r  <= load_count;
    end else if (valid_r && rsp_ready) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign rsp_valid  = valid_r;
  assign rsp_code   = code_r;
  assign rsp_cycles = cycles_r;
  assign rsp_count  = count_r;

endmodule

// File: rtl/count_ctrl.sv
// Initiator for an up-counting sub-counter: command in, clear/start/watch, response out.
// Optional build macro COUNT_CTRL_CHECK_EN turns an OK with count != stopcount into MISMATCH.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CYC_W          = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_stop,
  input  logic             abort,
  output logic             ctr_resetn,
  output logic             ctr_start,
  output logic [31:0]      ctr_stopcount,
  input  logic             ctr_status,
  input  logic [31:0]      ctr_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_code,
  output logic [CYC_W-1:0] rsp_cycles,
  output logic [31:0]      rsp_count
);

  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYCLES - 32'd1);

  state_e           state_r;
  logic             cmd_ready_r;
  logic             ctr_resetn_r;
  logic             ctr_start_r;
  logic [31:0]      stopcount_r;
  logic [CYC_W-1:0] cyc_r;

  logic             finish_s;
  rsp_code_e        code_s;
  rsp_code_e        ok_code_s;
  logic             rsp_valid_s;
  rsp_code_e        rsp_code_s;
  logic             rsp_hs_s;

`ifdef COUNT_CTRL_CHECK_EN
  assign ok_code_s = (ctr_count != stopcount_r) ? RSP_MISMATCH : RSP_OK;
`else
  assign ok_code_s = RSP_OK;
`endif

  assign rsp_hs_s = rsp_valid_s & rsp_ready;

  // Completion decision for the current RUN cycle: abort, then status, then timeout.
  always_comb begin
    finish_s = 1'b0;
    code_s   = RSP_OK;
    if (state_r == ST_RUN) begin
      if (abort) begin
        finish_s = 1'b1;
        code_s   = RSP_ABORT;
      end else if (ctr_status) begin
        finish_s = 1'b1;
        code_s   = ok_code_s;
      end else if (cyc_r == TIMEOUT_LAST) begin
        finish_s = 1'b1;
        code_s   = RSP_TIMEOUT;
      end else begin
        finish_s = 1'b0;
        code_s   = RSP_OK;
      end
    end else begin
      finish_s = 1'b0;
      code_s   = RSP_OK;
    end
  end

  // Control FSM with registered counter-side and command-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      cmd_ready_r  <= 1'b0;
      ctr_resetn_r <= 1'b0;
      ctr_start_r  <= 1'b0;
      stopcount_r  <= 32'd0;
      cyc_r        <= {CYC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            state_r      <= ST_RUN;
            cmd_ready_r  <= 1'b0;
            ctr_resetn_r <= 1'b1;
            ctr_start_r  <= 1'b1;
            stopcount_r  <= cmd_stop;
            cyc_r        <= {CYC_W{1'b0}};
          end else begin
            cmd_ready_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (finish_s) begin
            state_r     <= ST_DONE;
            ctr_start_r <= 1'b0;
          end else if (cyc_r != {CYC_W{1'b1}}) begin
            cyc_r <= cyc_r + CYC_W'(1);
          end else begin
            cyc_r <= cyc_r;
          end
        end
        ST_DONE: begin
          if (rsp_hs_s) begin
            state_r      <= ST_IDLE;
            ctr_resetn_r <= 1'b0;
            cmd_ready_r  <= 1'b1;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cmd_ready_r  <= 1'b0;
          ctr_resetn_r <= 1'b0;
          ctr_start_r  <= 1'b0;
        end
      endcase
    end
  end

  count_ctrl_rsp_reg #(
    .CYC_W (CYC_W)
  ) u_rsp_reg (
    .clk         (clk),
    .resetn      (resetn),
    .load        (finish_s),
    .load_code   (code_s),
    .load_cycles (cyc_r),
    .load_count  (ctr_count),
    .rsp_ready   (rsp_ready),
    .rsp_valid   (rsp_valid_s),
    .rsp_code    (rsp_code_s),
    .rsp_cycles  (rsp_cycles),
    .rsp_count   (rsp_count)
  );

  assign cmd_ready     = cmd_ready_r;
  assign ctr_resetn    = ctr_resetn_r;
  assign ctr_start     = ctr_start_r;
  assign ctr_stopcount = stopcount_r;
  assign rsp_valid     = rsp_valid_s;
  assign rsp_code      = rsp_code_s;

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: attached up-counter model, per-run outcome model, directed runs.
module tb_count_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_stop = 32'd0;
  logic        abort = 1'b0;
  logic        ctr_resetn;
  logic        ctr_start;
  logic [31:0] ctr_stopcount;
  logic        ctr_status;
  logic [31:0] ctr_count;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_cycles;
  logic [31:0] rsp_count;

  int tests = 0;
  int fails = 0;

  // expected response of the run in flight
  int exp_code, exp_cyc, exp_cnt;
  logic [31:0] exp_stop = 32'd0;
  logic [31:0] bump = 32'd0;

  count_ctrl #(.TIMEOUT_CYCLES(TO), .CYC_W(32)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_stop(cmd_stop), .abort(abort), .ctr_resetn(ctr_resetn), .ctr_start(ctr_start),
    .ctr_stopcount(ctr_stopcount), .ctr_status(ctr_status), .ctr_count(ctr_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
    .rsp_cycles(rsp_cycles), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  // Up-counter: cleared while its resetn is low, counts to stopcount while started.
  logic [31:0] cnt;
  always @(posedge clk or negedge ctr_resetn) begin
    if (!ctr_resetn) cnt <= 32'd0;
    else if (ctr_start && cnt < ctr_stopcount) cnt <= cnt + 32'd1;
  end
  assign ctr_status = ctr_resetn && (cnt >= ctr_stopcount);
  assign ctr_count  = cnt + bump;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Outcome of a run: first RUN cycle (1-based) on which abort, status or timeout ends it.
  function automatic void model(input int stop, input int ab, input int bmp,
                                output int code, output int cyc, output int cnt_o, output int endk);
    if (stop + 1 <= TO) begin endk = stop + 1; code = 0; end
    else begin endk = TO; code = 1; end
    if (ab != 0 && ab <= endk) begin endk = ab; code = 2; end
    cyc   = endk - 1;
    cnt_o = endk - 1 + bmp;
    if (code == 0 && bmp != 0) code = 3;
  endfunction

  // Whenever a response is presented it must match the model and the counter must be idle-held.
  always @(negedge clk) begin
    if (resetn && rsp_valid) begin
      check("rsp_code_stable", rsp_code, exp_code);
      check("rsp_cycles_stable", rsp_cycles, exp_cyc);
      check("rsp_count_stable", rsp_count, exp_cnt);
      check("done_start_low", ctr_start, 0);
      check("done_cmd_ready_low", cmd_ready, 0);
    end
    if (resetn && ctr_start) begin
      check("run_stopcount", ctr_stopcount, exp_stop);
      check("run_ctr_resetn", ctr_resetn, 1);
    end
  end

  task automatic issue(input int stop);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    check("cmd_ready_wait", cmd_ready, 1);
    exp_stop  = stop;
    cmd_valid = 1'b1;
    cmd_stop  = stop;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_stop  = 32'hDEAD_BEEF;
  endtask

  task automatic run(input int stop, input int ab, input int hold,
                     input int l_code, input int l_cyc, input int l_cnt, input int l_start);
    int m_code, m_cyc, m_cnt, m_end, k, starts;
    model(stop, ab, bump, m_code, m_cyc, m_cnt, m_end);
    check("model_pin", {m_code == l_code, m_cyc == l_cyc, m_cnt == l_cnt, m_end == l_start}, 4'hF);
    exp_code = m_code; exp_cyc = m_cyc; exp_cnt = m_cnt;
    rsp_ready = (hold == 0);
    issue(stop);
    k = 0; starts = 0;
    while (k < 200) begin
      @(negedge clk);
      if (rsp_valid) break;
      k++;
      starts += int'(ctr_start);
      abort = (k == ab);
    end
    abort = 1'b0;
    check("rsp_valid_seen", rsp_valid, 1);
    check("start_cycles", starts, m_end);
    check("rsp_code", rsp_code, m_code);
    check("rsp_cycles", rsp_cycles, m_cyc);
    check("rsp_count", rsp_count, m_cnt);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("after_hs_cmd_ready", cmd_ready, 1);
    check("after_hs_rsp_valid", rsp_valid, 0);
    check("after_hs_ctr_resetn", ctr_resetn, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #13;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ctr_resetn", ctr_resetn, 0);
    check("rst_ctr_start", ctr_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_stopcount", ctr_stopcount, 0);
    check("rst_rsp_fields", {rsp_code, rsp_cycles, rsp_count}, 0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);

    run(5,   0, 0,  0, 5, 5, 6);
    run(0,   0, 0,  0, 0, 0, 1);
    run(100, 0, 0,  1, 7, 7, 8);
    run(7,   0, 0,  0, 7, 7, 8);   // status and timeout together: status wins
    run(20,  4, 0,  2, 3, 3, 4);
    run(2,   0, 0,  0, 2, 2, 3);
    run(5,   0, 10, 0, 5, 5, 6);

    // reset in the middle of a run
    exp_code = 0; exp_cyc = 0; exp_cnt = 0;
    issue(50);
    repeat (5) @(negedge clk);
    check("midrun_start_high", ctr_start, 1);
    #2 resetn = 1'b0;
    #1;
    check("midrun_rst_start", ctr_start, 0);
    check("midrun_rst_ctr_resetn", ctr_resetn, 0);
    check("midrun_rst_cmd_ready", cmd_ready, 0);
    check("midrun_rst_rsp_valid", rsp_valid, 0);
    check("midrun_rst_stopcount", ctr_stopcount, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    check("post_rst_cmd_ready", cmd_ready, 1);
    run(3, 0, 0, 0, 3, 3, 4);

`ifdef COUNT_CTRL_CHECK_EN
    bump = 32'd1;
    run(3, 0, 0, 3, 3, 4, 4);
    bump = 32'd0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
